// File: rtl/mod_check_arbiter.sv
// Round-robin share of one MSB-first mod-MOD remainder engine; accept->rsp_valid W cycles, next grant >= W+2.
// Backpressure: req_ready only in IDLE; response regs hold in DONE until rsp_ready.
module mod_check_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 8,
  parameter int MOD  = 5,
  parameter int IDW  = $clog2(NREQ),
  parameter int RW   = $clog2(MOD)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [RW-1:0]       rsp_rem,
  output logic                rsp_div,
  output logic                busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id;
  logic [W-1:0]    sreg;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   rem;

  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW:0]    sum;
  logic [W-1:0]    gnt_word;
  logic [RW:0]     nxt;
  logic [RW-1:0]   rem_nxt;

  // Scan from the highest offset down so the nearest valid requester after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (req_valid[sum[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) gnt_word = req_data[i*W +: W];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  // 2*rem + msb is always < 2*MOD, so one conditional subtract keeps rem reduced.
  assign nxt     = {rem, sreg[W-1]};
  assign rem_nxt = (nxt >= (RW+1)'(MOD)) ? RW'(nxt - (RW+1)'(MOD)) : RW'(nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      sreg      <= '0;
      cnt       <= '0;
      rem       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rem   <= '0;
      rsp_div   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            sreg  <= gnt_word;
            rem   <= '0;
            cnt   <= CW'(W);
            id    <= gnt_idx;
            ptr   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          rem  <= rem_nxt;
          sreg <= sreg << 1;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_rem   <= rem_nxt;
            rsp_div   <= (rem_nxt == '0);
            rsp_id    <= id;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_check_arbiter.sv
// Scoreboard bench for mod_check_arbiter: accepted words push word%MOD, responses pop and compare.
module tb_mod_check_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int MOD  = 5;
  localparam int IDW  = $clog2(NREQ);
  localparam int RW   = $clog2(MOD);
  localparam int NWORDS = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [RW-1:0]     rsp_rem;
  logic              rsp_div;
  logic              busy;

  mod_check_arbiter #(.NREQ(NREQ), .W(W), .MOD(MOD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_rem(rsp_rem), .rsp_div(rsp_div), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int rem; int acc; } exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int word_of(input int i);
    logic [W-1:0] w;
    w = W'(req_data >> (i * W));
    return int'(w);
  endfunction

  // Reference arbiter and expected-response producer.
  int mptr = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mptr = 0;
      sbq.delete();
    end else if (busy) begin
      check("no_grant_while_busy", int'(req_ready), 0);
    end else begin
      int eg;
      eg = exp_grant(req_valid, mptr);
      check("grant", int'(req_ready), (eg < 0) ? 0 : (1 << eg));
      if (eg >= 0 && req_ready[eg]) begin
        sbq.push_back('{id: eg, rem: word_of(eg) % MOD, acc: cyc + 1});
        mptr = (eg + 1) % NREQ;
      end
    end
  end

  logic           prev_vld = 1'b0;
  logic           prev_stall = 1'b0;
  logic [IDW-1:0] prev_id = '0;
  logic [RW-1:0]  prev_rem = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", int'(rsp_valid), 1);
        check("hold_id", int'(rsp_id), int'(prev_id));
        check("hold_rem", int'(rsp_rem), int'(prev_rem));
      end
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: id %0d rem %0d with nothing pending", rsp_id, rsp_rem);
        end else begin
          if (!prev_vld) check("latency", cyc - sbq[0].acc, W);
          if (rsp_ready) begin
            exp_t e;
            e = sbq.pop_front();
            check("rsp_id", int'(rsp_id), e.id);
            check("rsp_rem", int'(rsp_rem), e.rem);
            check("rsp_div", int'(rsp_div), (e.rem == 0) ? 1 : 0);
          end
        end
      end
      prev_vld   = rsp_valid;
      prev_stall = rsp_valid && !rsp_ready;
      prev_id    = rsp_id;
      prev_rem   = rsp_rem;
    end
  end

  task automatic set_word(input int i, input logic [W-1:0] w);
    req_data[i*W +: W] = w;
  endtask

  task automatic wait_hs(input int i);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    timeout("wait_accept");
  endtask

  task automatic wait_any(output int id, output int c_at);
    id = -1;
    c_at = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
        c_at = cyc;
        @(posedge clk);
        #1;
        return;
      end
    end
    timeout("wait_any_accept");
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    timeout("wait_idle");
  endtask

  task automatic single(input int i, input logic [W-1:0] w);
    set_word(i, w);
    req_valid[i] = 1'b1;
    wait_hs(i);
    req_valid[i] = 1'b0;
    set_word(i, W'($urandom));
    wait_idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_random();
    int sent [NREQ];
    logic [NREQ-1:0] hs;
    int pick;
    logic [W-1:0] w;
    for (int i = 0; i < NREQ; i++) sent[i] = 0;
    for (int c = 0; c < 20000; c++) begin
      if (sent[0] >= NWORDS && sent[1] >= NWORDS) break;
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        pick = $urandom_range(0, 9);
        w = (pick == 0) ? '0 : (pick == 1) ? '1 : W'($urandom);
        if (hs[i]) begin
          sent[i]++;
          req_valid[i] = 1'b0;
          set_word(i, w);
        end else if (req_valid[i] && $urandom_range(0, 99) < 5) begin
          req_valid[i] = 1'b0;
          set_word(i, w);
        end else if (!req_valid[i] && sent[i] < NWORDS && $urandom_range(0, 99) < 40) begin
          set_word(i, w);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) check("random_words_sent", sent[i], NWORDS);
    wait_idle();
  endtask

  initial begin
    int id0, id1, id2, c0, c1, c2;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    check("rst_rsp_rem", int'(rsp_rem), 0);
    check("rst_rsp_div", int'(rsp_div), 0);
    rst_n = 1'b1;

    single(0, 8'd10);
    single(1, 8'd23);
    single(0, 8'hFF);
    single(1, 8'd0);

    // Both requesters valid continuously straight out of reset.
    do_reset();
    set_word(0, 8'd7);
    set_word(1, 8'd12);
    req_valid = '1;
    wait_any(id0, c0);
    wait_any(id1, c1);
    wait_any(id2, c2);
    req_valid = '0;
    check("rotate_first", id0, 0);
    check("rotate_second", id1, 1);
    check("rotate_third", id2, 0);
    check("accept_spacing_a", c1 - c0, W + 2);
    check("accept_spacing_b", c2 - c1, W + 2);
    wait_idle();

    // Stall the response for five cycles while another requester waits.
    rsp_ready = 1'b0;
    set_word(0, 8'd33);
    req_valid[0] = 1'b1;
    wait_hs(0);
    req_valid[0] = 1'b0;
    set_word(1, 8'd44);
    req_valid[1] = 1'b1;
    for (int c = 0; c < 200 && !rsp_valid; c++) @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stall_rsp_valid", int'(rsp_valid), 1);
    check("stall_req_ready", int'(req_ready), 0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_idle_busy", int'(busy), 0);
    check("release_idle_valid", int'(rsp_valid), 0);
    @(posedge clk);
    #1;
    check("next_grant_busy", int'(busy), 1);
    req_valid[1] = 1'b0;
    wait_idle();

    // Reset in the middle of a shift abandons the word and rewinds the pointer.
    set_word(0, 8'd77);
    req_valid[0] = 1'b1;
    wait_hs(0);
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", int'(rsp_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_rsp_id", int'(rsp_id), 0);
    check("midrst_rsp_rem", int'(rsp_rem), 0);
    check("midrst_rsp_div", int'(rsp_div), 0);
    set_word(0, 8'd9);
    set_word(1, 8'd15);
    req_valid = '1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_any(id0, c0);
    req_valid = '0;
    check("post_reset_first_grant", id0, 0);
    wait_idle();

    run_random();
    check("scoreboard_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_check_arbiter.md
Name: mod_check_arbiter

Overview:
Shares one serial modulo-MOD remainder engine between NREQ requesters. The engine is the MSB-first "divisible by N" FSM: per bit, rem <= (2*rem + bit) mod MOD. A round-robin arbiter grants one requester at a time. The block captures that requester's W-bit word, shifts it through the engine MSB-first, then returns the remainder and a divisible flag tagged with the requester id. It sits between parallel producers and the serial divisibility datapath, replacing per-requester checker instances.

Parameters:
NREQ, 2, number of requesters (>=2)
W, 8, width of each request word in bits (>=1)
MOD, 5, modulus of the remainder engine (>=2)
IDW, $clog2(NREQ), width of response id (derived)
RW, $clog2(MOD), width of remainder (derived)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_data  input  NREQ*W  request words; requester i occupies bits [i*W +: W]
req_ready  output  NREQ  per-requester accept; at most one bit high
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  IDW  index of requester the response belongs to
rsp_rem  output  RW  remainder word mod MOD
rsp_div  output  1  1 when rsp_rem == 0
busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- On rst_n low, immediately: state=IDLE, rr pointer=0, rem=0, bit counter=0, rsp_valid=0, rsp_id=0, rsp_rem=0, rsp_div=0, busy=0. Reset mid-operation abandons the in-flight word; no response is produced for it.
- States: IDLE, SHIFT, DONE.
- IDLE arbitration:
  - Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ... with wrap modulo NREQ.
  - req_ready[grant]=1 combinationally in IDLE only. All req_ready bits are 0 in SHIFT and DONE, and 0 when no req_valid is set.
  - Handshake (req_valid[i] && req_ready[i]) at edge t: capture req_data slice into shift register, rem<=0, counter<=W, id<=i, ptr<=(i+1) mod NREQ, state<=SHIFT.
- SHIFT, one bit per cycle, MSB first:
  - next = 2*rem + msb, computed at RW+1 bits.
  - rem <= (next >= MOD) ? next-MOD : next. Single conditional subtract; no divider.
  - Shift register shifts left; counter decrements.
  - When the W-th bit is consumed (edge t+W): state<=DONE, rsp_valid<=1, rsp_rem<=final rem, rsp_div<=(final rem==0), rsp_id<=id.
- DONE:
  - Outputs hold stable while rsp_valid && !rsp_ready.
  - On the handshake edge: rsp_valid<=0, state<=IDLE.
  - Outputs stay registered; no combinational path from rsp_ready to outputs.
- Latency and throughput:
  - rsp_valid is high after edge t+W.
  - With rsp_ready=1, the next grant occurs no earlier than edge t+W+2. Peak throughput is 1 word per W+2 cycles.
- Boundary cases:
  - Requester dropping req_valid while not granted: ignored; no state kept.
  - req_data changing after capture: no effect on the in-flight word.
  - All requesters valid continuously: grants rotate 0,1,...,NREQ-1,0; no starvation.
  - W=1: SHIFT lasts one cycle.
  - Word 0: rem=0, rsp_div=1.

Test Plan:
- Reset, then req_valid[0]=1, req_data[0]=8'd10 -> req_ready[0] one cycle; rsp_valid 8 cycles after accept; rsp_id=0, rsp_rem=0, rsp_div=1.
- req_data[1]=8'd23 alone -> rsp_id=1, rsp_rem=3, rsp_div=0. Word 8'hFF -> rsp_rem=0, rsp_div=1. Word 8'd0 -> rsp_rem=0, rsp_div=1.
- Both req_valid high from reset, words 7 and 12, rsp_ready=1 -> responses in order id0 (rem 2), id1 (rem 2), id0 again; successive accepts spaced W+2=10 cycles.
- Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid/rsp_id/rsp_rem stable; all req_ready=0; release -> IDLE next edge, then next grant.
- Assert rst_n=0 mid-SHIFT (after 3 bits) -> outputs zero immediately; after release, no response for the abandoned word; ptr=0 so requester 0 is granted first.
- 100 random words per requester, random valids and rsp_ready -> every rsp_rem equals reference word % 5; rsp_div==(rsp_rem==0); no grant while busy.
